// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file.
// One write port (WB), NUM_RD combinational read ports (ID), a post-reset
// clear sequencer that zeroes every register before reporting ready, and a
// per-register busy scoreboard for in-flight writes.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       set_en,
  input  logic [ADDR_W-1:0]          set_addr,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] clr_idx_next;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_hit;
  logic              set_hit;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be in the range 1..4");
  end

  // x0 is hardwired, so writes and issues targeting it never take effect
  assign wr_hit  = we && (waddr != '0);
  assign set_hit = set_en && (set_addr != '0);
  assign ready   = (state == RUN);

  // State and clear-index registers; reset always restarts the clear sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // Sweep one register per cycle in CLEAR; leave after the last index is written
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    if (state == CLEAR) begin
      clr_idx_next = clr_idx + ADDR_W'(1);
      if (clr_idx == {ADDR_W{1'b1}}) begin
        state_next = RUN;
      end
    end
  end

  // Register array: zeroed by the sweep, then written from WB once running
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (wr_hit) begin
        regs[waddr] <= wdata;
      end
    end
  end

  // Busy scoreboard: WB clears, ID sets; a same-cycle set overrides the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state == RUN) begin
      if (wr_hit) begin
        busy[waddr] <= 1'b0;
      end
      if (set_hit) begin
        busy[set_addr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              active;
    logic              byp;

    assign ra     = raddr[i*ADDR_W +: ADDR_W];
    assign active = !rst && ready && re[i] && (ra != '0);
`ifdef REGFILE_BYPASS_EN
    assign byp    = wr_hit && ready && (ra == waddr);
`else
    assign byp    = 1'b0;
`endif
    assign rdata[i*DATA_W +: DATA_W] = !active ? '0 : (byp ? wdata : regs[ra]);
    assign rbusy[i] = re[i] && ready && busy[ra] && !byp;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed stimulus for regfile_mp (4 read
// ports), checked every cycle against a behavioural model built from
// arrays and a cycle counter.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 4;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ready;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     set_en;
  logic [ADDR_W-1:0]        set_addr;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;

  int err_count   = 0;
  int check_count = 0;

  logic [DATA_W-1:0] m_regs [DEPTH];
  logic              m_busy [DEPTH];
  logic              m_ready;
  int                m_clr_cycles;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .set_en(set_en), .set_addr(set_addr),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NUM_RD*ADDR_W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
  endfunction

  task automatic compareAll();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp_d;
    logic              exp_b;
    logic              hit;
    checkOutput("ready", 64'(ready), 64'(m_ready));
    for (int i = 0; i < NUM_RD; i++) begin
      a   = raddr[i*ADDR_W +: ADDR_W];
      hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      hit = we && (waddr != 0) && m_ready && (a == waddr);
`endif
      if (rst || !m_ready || !re[i] || a == 0) exp_d = '0;
      else if (hit)                            exp_d = wdata;
      else                                     exp_d = m_regs[a];
      exp_b = re[i] && m_ready && m_busy[a] && !hit;
      checkOutput($sformatf("rdata%0d_x%0d", i, a), 64'(rdata[i*DATA_W +: DATA_W]), 64'(exp_d));
      checkOutput($sformatf("rbusy%0d_x%0d", i, a), 64'(rbusy[i]), 64'(exp_b));
    end
  endtask

  task automatic updateModel();
    if (rst) begin
      m_ready      = 1'b0;
      m_clr_cycles = 0;
      for (int r = 0; r < DEPTH; r++) begin
        m_busy[r] = 1'b0;
        m_regs[r] = '0;
      end
    end else if (!m_ready) begin
      m_clr_cycles++;
      if (m_clr_cycles == DEPTH) m_ready = 1'b1;
    end else begin
      if (we && waddr != 0) begin
        m_regs[waddr] = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input int wa, input logic [DATA_W-1:0] wd,
                               input logic s, input int sa, input logic [NUM_RD-1:0] rev,
                               input logic [NUM_RD*ADDR_W-1:0] ra);
    rst      = r;
    we       = w;
    waddr    = ADDR_W'(wa);
    wdata    = wd;
    set_en   = s;
    set_addr = ADDR_W'(sa);
    re       = rev;
    raddr    = ra;
    #1;
    compareAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic randomCycle(input int rst_odds);
    logic [NUM_RD*ADDR_W-1:0] ra;
    for (int i = 0; i < NUM_RD; i++)
      ra[i*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, 31));
    applyStimulus(($urandom_range(1, rst_odds) == 1), 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom(),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7), NUM_RD'($urandom_range(0, 15)), ra);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    set_en = 1'b0; set_addr = '0; re = '0; raddr = '0;
    @(posedge clk);
    updateModel();
    #1;

    // Reset held for two cycles, then the 32-cycle clear sweep
    applyStimulus(1, 0, 0, 0, 0, 0, 4'hF, pack4(1, 2, 3, 4));
    applyStimulus(1, 0, 0, 0, 0, 0, 4'hF, pack4(5, 6, 7, 8));
    for (int c = 0; c < DEPTH; c++) begin
      if (c == 3) applyStimulus(0, 1, 5, 32'hDEADBEEF, 1, 5, 4'hF, pack4(5, 1, 31, 5));
      else        applyStimulus(0, 1'($urandom_range(0, 1)), $urandom_range(1, 31), $urandom(), 1, 9,
                                4'hF, pack4(c, 31 - c, 5, 9));
    end
    checkOutput("ready_after_32_edges", 64'(ready), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'hF, pack4(5, 9, 31, 1));

    // Basic write/read and x0 protection
    applyStimulus(0, 1, 7, 32'h12345678, 0, 0, 4'h0, pack4(0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h3, pack4(7, 0, 0, 0));
    checkOutput("lit_x7_after_write", 64'(m_regs[7]), 64'h12345678);
    applyStimulus(0, 1, 0, 32'hFFFFFFFF, 1, 0, 4'hF, pack4(0, 0, 7, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 4'hF, pack4(0, 0, 0, 0));

    // Same-cycle write and read of x3
    applyStimulus(0, 1, 3, 32'hA5A5A5A5, 0, 0, 4'h2, pack4(0, 3, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h2, pack4(0, 3, 0, 0));

    // Scoreboard: set x9, hold, clear by write, then simultaneous set+write
    applyStimulus(0, 0, 0, 0, 1, 9, 4'h1, pack4(9, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h1, pack4(9, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h1, pack4(9, 0, 0, 0));
    applyStimulus(0, 1, 9, 32'h00000099, 0, 0, 4'h1, pack4(9, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h1, pack4(9, 0, 0, 0));
    applyStimulus(0, 1, 9, 32'h00000999, 1, 9, 4'h3, pack4(9, 9, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 4'h3, pack4(9, 9, 0, 0));

    // Four ports reading x1, x2, x1, x0
    applyStimulus(0, 1, 1, 32'd1, 0, 0, 4'h0, pack4(0, 0, 0, 0));
    applyStimulus(0, 1, 2, 32'd2, 0, 0, 4'h0, pack4(0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 4'hF, pack4(1, 2, 1, 0));

    // Reset mid-clear at index 10 with busy bits set beforehand
    applyStimulus(0, 0, 0, 0, 1, 12, 4'h0, pack4(0, 0, 0, 0));
    applyStimulus(1, 0, 0, 0, 0, 0, 4'hF, pack4(9, 12, 1, 2));
    for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, 0, 0, 0, 4'hF, pack4(9, 12, 1, 2));
    applyStimulus(1, 0, 0, 0, 0, 0, 4'hF, pack4(9, 12, 1, 2));
    for (int c = 0; c < DEPTH; c++) begin
      if (c == DEPTH - 1) checkOutput("ready_low_before_32nd_edge", 64'(ready), 64'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 4'hF, pack4(9, 12, 1, 2));
    end
    checkOutput("ready_after_restart", 64'(ready), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 4'hF, pack4(9, 12, 1, 2));

    // Randomized traffic with occasional resets
    for (int c = 0; c < 400; c++) randomCycle(150);
    for (int c = 0; c < 40; c++) randomCycle(1000000);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
